// File: rtl/store_monitor.sv
// store_monitor: watches the single-cycle MIPS data-memory write port.
//
// Every store (memwrite high) is pushed as {dataadr, writedata} into an in-order
// FIFO drained over a valid/ready handshake. Two programmable (address, data)
// store signatures set sticky hit flags, and done rises once both have been seen.
//
// Optional feature macro: STORE_MON_COUNT_EN
//   defined     -> store_count counts every store (dropped ones included),
//                  saturating at 16'hFFFF
//   not defined -> store_count is tied to 0 and no counter is built
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset        synchronous active-high reset
//   memwrite     store strobe from CPU
//   dataadr      store byte address
//   writedata    store data
//   out_valid    FIFO head available
//   out_ready    consumer accepts head this cycle
//   out_addr     head address (0 when empty)
//   out_data     head data (0 when empty)
//   level        FIFO occupancy, 0..DEPTH
//   overflow     sticky, a store was dropped on a full FIFO
//   hit0, hit1   sticky signature hits
//   done         sticky, both hits seen (one edge after the later hit)
//   store_count  total stores observed
module store_monitor #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [31:0] MATCH0_ADDR = 32'd84,
  parameter logic [31:0] MATCH0_DATA = 32'h0000_9504,
  parameter logic [31:0] MATCH1_ADDR = 32'd88,
  parameter logic [31:0] MATCH1_DATA = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwrite,
  input  logic [31:0]                dataadr,
  input  logic [31:0]                writedata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_addr,
  output logic [31:0]                out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       hit0,
  output logic                       hit1,
  output logic                       done,
  output logic [15:0]                store_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

  logic [31:0]     addr_mem [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            hit0_q, hit0_d;
  logic            hit1_q, hit1_d;
  logic            done_q, done_d;

  logic full, pop, push, match0, match1;

  assign full   = (count_q == LvlFull);
  assign pop    = out_valid && out_ready;
  // A full FIFO still accepts a store when the head leaves on the same edge.
  assign push   = memwrite && (!full || pop);
  // Signatures compare raw inputs so that dropped stores can still hit.
  assign match0 = memwrite && (dataadr == MATCH0_ADDR) && (writedata == MATCH0_DATA);
  assign match1 = memwrite && (dataadr == MATCH1_ADDR) && (writedata == MATCH1_DATA);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    hit0_d     = hit0_q || match0;
    hit1_d     = hit1_q || match1;
    done_d     = done_q || (hit0_q && hit1_q);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + LvlW'(1);
    end else if (pop && !push) begin
      count_d = count_q - LvlW'(1);
    end
    if (memwrite && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      hit0_q     <= 1'b0;
      hit1_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      hit0_q     <= hit0_d;
      hit1_q     <= hit1_d;
      done_q     <= done_d;
    end
  end

  // Storage needs no reset: the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      addr_mem[wr_ptr_q] <= dataadr;
      data_mem[wr_ptr_q] <= writedata;
    end
  end

  always_comb begin
    out_valid = (count_q != '0);
    out_addr  = out_valid ? addr_mem[rd_ptr_q] : 32'd0;
    out_data  = out_valid ? data_mem[rd_ptr_q] : 32'd0;
  end

  assign level    = count_q;
  assign overflow = overflow_q;
  assign hit0     = hit0_q;
  assign hit1     = hit1_q;
  assign done     = done_q;

`ifdef STORE_MON_COUNT_EN
  logic [15:0] store_count_q, store_count_d;

  always_comb begin
    store_count_d = store_count_q;
    if (memwrite && (store_count_q != 16'hFFFF)) begin
      store_count_d = store_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      store_count_q <= 16'd0;
    end else begin
      store_count_q <= store_count_d;
    end
  end

  assign store_count = store_count_q;
`else
  assign store_count = 16'd0;
`endif

endmodule

// File: tb/tb_store_monitor.sv
// Bench for store_monitor: directed stimulus, a queue-based reference model,
// a full output compare after every clock, and literal spot checks.
module tb_store_monitor;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] M0A = 32'd84;
  localparam logic [31:0] M0D = 32'h0000_9504;
  localparam logic [31:0] M1A = 32'd88;
  localparam logic [31:0] M1D = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  level;
  logic        overflow;
  logic        hit0;
  logic        hit1;
  logic        done;
  logic [15:0] store_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  logic [63:0] mq[$];
  bit          m_ovf, m_h0, m_h1, m_done;
  int          m_cnt;

  store_monitor #(
    .DEPTH      (DEPTH),
    .MATCH0_ADDR(M0A),
    .MATCH0_DATA(M0D),
    .MATCH1_ADDR(M1A),
    .MATCH1_DATA(M1D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .level      (level),
    .overflow   (overflow),
    .hit0       (hit0),
    .hit1       (hit1),
    .done       (done),
    .store_count(store_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic mw, input logic [31:0] a, input logic [31:0] d,
                            input logic rdy, input logic rst);
    bit do_pop;
    if (rst) begin
      mq.delete();
      m_ovf  = 0;
      m_h0   = 0;
      m_h1   = 0;
      m_done = 0;
      m_cnt  = 0;
    end else begin
      do_pop = (mq.size() > 0) && rdy;
      if (m_h0 && m_h1) m_done = 1;
      if (mw && a == M0A && d == M0D) m_h0 = 1;
      if (mw && a == M1A && d == M1D) m_h1 = 1;
      if (do_pop) void'(mq.pop_front());
      if (mw) begin
        if (mq.size() < DEPTH) mq.push_back({a, d});
        else m_ovf = 1;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] ea, ed;
    ea = (mq.size() > 0) ? mq[0][63:32] : 32'd0;
    ed = (mq.size() > 0) ? mq[0][31:0] : 32'd0;
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    chk("out_addr", out_addr, ea);
    chk("out_data", out_data, ed);
    chk("level", {28'd0, level}, 32'(mq.size()));
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("hit0", {31'd0, hit0}, {31'd0, m_h0});
    chk("hit1", {31'd0, hit1}, {31'd0, m_h1});
    chk("done", {31'd0, done}, {31'd0, m_done});
`ifdef STORE_MON_COUNT_EN
    chk("store_count", {16'd0, store_count}, 32'(m_cnt));
`else
    chk("store_count", {16'd0, store_count}, 32'd0);
`endif
  endtask

  // Drive inputs, take one rising edge, update the model, compare on the falling edge.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                      input logic rdy, input logic rst);
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    out_ready = rdy;
    reset     = rst;
    @(posedge clk);
    model_edge(mw, a, d, rdy, rst);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    // Reset held 3 cycles with a matching store presented.
    for (int i = 0; i < 3; i++) step(1'b1, 32'd84, 32'h9504, 1'b0, 1'b1);
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_hit0", {31'd0, hit0}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_count", {16'd0, store_count}, 32'd0);
    chk("rst_model_level", 32'(mq.size()), 32'd0);

    // First signature store.
    step(1'b1, 32'd84, 32'h9504, 1'b0, 1'b0);
    chk("p1_valid", {31'd0, out_valid}, 32'd1);
    chk("p1_addr", out_addr, 32'd84);
    chk("p1_data", out_data, 32'h9504);
    chk("p1_level", {28'd0, level}, 32'd1);
    chk("p1_hit0", {31'd0, hit0}, 32'd1);
    chk("p1_done", {31'd0, done}, 32'd0);
    chk("p1_model_hit0", {31'd0, m_h0}, 32'd1);

    // Second signature store; done follows one edge later.
    step(1'b1, 32'd88, 32'd0, 1'b0, 1'b0);
    chk("p2_hit1", {31'd0, hit1}, 32'd1);
    chk("p2_done", {31'd0, done}, 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("p3_done", {31'd0, done}, 32'd1);
    chk("p3_addr", out_addr, 32'd88);
    chk("p3_model_done", {31'd0, m_done}, 32'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("p4_level", {28'd0, level}, 32'd0);
    chk("p4_valid", {31'd0, out_valid}, 32'd0);
    chk("p4_addr", out_addr, 32'd0);

    // Overflow: nine stores into an 8-deep FIFO.
    for (int i = 0; i < 9; i++) step(1'b1, 32'(4 * i), 32'(i), 1'b0, 1'b0);
    chk("ovf_level", {28'd0, level}, 32'd8);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("ovf_drain1_addr", out_addr, 32'd4);
    chk("ovf_drain1_data", out_data, 32'd1);
    for (int i = 0; i < 7; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("ovf_empty", {28'd0, level}, 32'd0);

    // Full FIFO with simultaneous push and pop.
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    for (int i = 10; i < 18; i++) step(1'b1, 32'(4 * i), 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'd200, 32'hABCD, 1'b1, 1'b0);
    chk("fpp_level", {28'd0, level}, 32'd8);
    chk("fpp_ovf", {31'd0, overflow}, 32'd0);
    chk("fpp_head", out_addr, 32'd44);
`ifdef STORE_MON_COUNT_EN
    chk("fpp_count", {16'd0, store_count}, 32'd9);
`else
    chk("fpp_count", {16'd0, store_count}, 32'd0);
`endif
    for (int i = 0; i < 7; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("fpp_last_addr", out_addr, 32'd200);
    chk("fpp_last_data", out_data, 32'hABCD);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("fpp_empty", {31'd0, out_valid}, 32'd0);

    // Near-miss signatures must not hit.
    step(1'b1, 32'd84, 32'h9505, 1'b0, 1'b0);
    step(1'b1, 32'd85, 32'h9504, 1'b0, 1'b0);
    chk("nm_hit0", {31'd0, hit0}, 32'd0);

    // Reset mid-drain with 3 entries queued.
    step(1'b1, 32'd88, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("mr_level_pre", {28'd0, level}, 32'd2);
    step(1'b1, 32'd84, 32'h9504, 1'b1, 1'b1);
    chk("mr_level", {28'd0, level}, 32'd0);
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_flags", {28'd0, overflow, hit0, hit1, done}, 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
